// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one ALU between two requesters; ports: clk/rst, req0_*/req1_* valid-ready operand channels, resp_* valid-ready result channel, busy
module alu_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_err,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic last, id_r, legal, g0, g1;
  logic [WIDTH-1:0] a_r, b_r, alu_out;
  logic [3:0] op_r;
  // on a tie the requester not granted last time wins
  assign g0 = req0_valid & (~req1_valid | last);
  assign g1 = req1_valid & (~req0_valid | ~last);
  assign req0_ready = (state == IDLE) & g0;
  assign req1_ready = (state == IDLE) & g1;
  assign resp_valid = state == RESP;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state == IDLE ? ((g0 | g1) ? EXEC : IDLE) :
              state == EXEC ? RESP :
              resp_ready ? IDLE : RESP;
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
  end
  always_comb begin
    alu_out = '0;
    legal = 1'b1;
    case (op_r)
      4'b0000: alu_out = a_r & b_r;
      4'b0001: alu_out = a_r | b_r;
      4'b0010: alu_out = a_r + b_r;
      4'b0011: alu_out = a_r << b_r[5:0];
      4'b0100: alu_out = {{(WIDTH-1){1'b0}}, $signed(a_r) < $signed(b_r)};
      4'b0110: alu_out = a_r - b_r;
      4'b0111: alu_out = a_r ^ b_r;
      4'b1000: alu_out = a_r >> b_r[5:0];
      default: legal = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (state == IDLE && (g0 || g1)) begin
      a_r  <= g1 ? req1_a : req0_a;
      b_r  <= g1 ? req1_b : req0_b;
      op_r <= g1 ? req1_op : req0_op;
      id_r <= g1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last        <= 1'b1;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      if (state == IDLE && (g0 || g1)) last <= g1;
      if (state == EXEC) begin
        resp_id     <= id_r;
        resp_result <= legal ? alu_out : '0;
        resp_zero   <= ~legal | (alu_out == '0);
        resp_err    <= ~legal;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter
module tb_alu_arbiter;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, resp_ready = 1;
  logic req0_ready, req1_ready, resp_valid, resp_id, resp_zero, resp_err, busy;
  logic [63:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, resp_result;
  logic [3:0] req0_op = 0, req1_op = 0;
  logic [66:0] sb[$];
  logic [66:0] exp, got;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_result(resp_result),
    .resp_zero(resp_zero), .resp_err(resp_err), .busy(busy)
  );

  task automatic send(input bit id, input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
    bit ok = 0;
    if (id) begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1; end
    else begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1; end
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = id ? req1_ready : req0_ready;
      @(posedge clk); #1;
    end
    if (id) req1_valid = 0; else req0_valid = 0;
    if (!ok) begin failures++; $display("FAIL accept_timeout id=%0d: ready never seen, expected ready", id); end
  endtask

  task automatic wait_resp();
    bit ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin failures++; $display("FAIL resp_timeout: resp_valid=0, expected 1"); end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    checks++;
    if ({resp_valid, resp_id, resp_result, resp_zero, resp_err, busy, req0_ready, req1_ready} !== 71'd0) begin
      failures++;
      $display("FAIL reset: got v=%b id=%b r=%h z=%b e=%b busy=%b rdy=%b%b, expected all 0",
               resp_valid, resp_id, resp_result, resp_zero, resp_err, busy, req0_ready, req1_ready);
    end
  endtask

  task automatic test_add();
    sb.push_back({1'b0, 64'd15, 1'b0, 1'b0});
    send(0, 64'd10, 64'd5, 4'b0010);
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL add_exec: got valid=%b busy=%b, expected valid=0 busy=1", resp_valid, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b1) begin failures++; $display("FAIL add_latency: got valid=%b, expected 1", resp_valid); end
    got = {resp_id, resp_result, resp_zero, resp_err}; exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL add: got %h expected %h", got, exp); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL add_idle: got busy=%b, expected 0", busy); end
  endtask

  task automatic test_zero_slt();
    sb.push_back({1'b1, 64'd0, 1'b1, 1'b0});
    send(1, 64'd100, 64'd100, 4'b0110);
    wait_resp();
    got = {resp_id, resp_result, resp_zero, resp_err}; exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL sub_zero: got %h expected %h", got, exp); end
    @(posedge clk); #1;
    sb.push_back({1'b1, 64'd1, 1'b0, 1'b0});
    send(1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd10, 4'b0100);
    wait_resp();
    got = {resp_id, resp_result, resp_zero, resp_err}; exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL slt: got %h expected %h", got, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic [3:0] g = 0;
    int n = 0;
    bit both = 0;
    rst = 1;
    @(posedge clk); #1;
    req0_a = 1; req0_b = 3; req0_op = 4'b0011; req0_valid = 1;
    req1_a = 64; req1_b = 2; req1_op = 4'b1000; req1_valid = 1;
    rst = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) both = 1;
      if (resp_valid) begin
        got = {resp_id, resp_result, resp_zero, resp_err}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL rr_result: got %h expected %h", got, exp); end
      end
      if (req0_ready || req1_ready) begin
        g[n] = req1_ready;
        sb.push_back(req1_ready ? {1'b1, 64'd16, 2'b00} : {1'b0, 64'd8, 2'b00});
        n++;
      end
      @(posedge clk);
    end
    #1 req0_valid = 0; req1_valid = 0;
    wait_resp();
    got = {resp_id, resp_result, resp_zero, resp_err}; exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL rr_last: got %h expected %h", got, exp); end
    @(posedge clk); #1;
    checks++;
    if (n != 4 || g !== 4'b1010 || both) begin
      failures++; $display("FAIL rr_order: got grants=%0d order=%b both=%b, expected 4 order=1010 both=0", n, g, both);
    end
  endtask

  task automatic test_backpressure();
    resp_ready = 0;
    sb.push_back({1'b0, 64'hFF, 1'b0, 1'b0});
    send(0, 64'hAA, 64'h55, 4'b0111);
    wait_resp();
    req1_a = 3; req1_b = 4; req1_op = 4'b0010; req1_valid = 1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_result !== 64'hFF || req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL stall: got v=%b r=%h rdy=%b%b busy=%b, expected v=1 r=ff rdy=00 busy=1",
                 resp_valid, resp_result, req0_ready, req1_ready, busy);
      end
      @(posedge clk); #1;
    end
    got = {resp_id, resp_result, resp_zero, resp_err}; exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL xor: got %h expected %h", got, exp); end
    resp_ready = 1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || req1_ready !== 1'b1) begin
      failures++; $display("FAIL release: got busy=%b v=%b rdy1=%b, expected 0 0 1", busy, resp_valid, req1_ready);
    end
    req1_valid = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    sb.push_back({1'b0, 64'd0, 1'b1, 1'b1});
    send(0, 64'd7, 64'd9, 4'b1010);
    wait_resp();
    got = {resp_id, resp_result, resp_zero, resp_err}; exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL illegal: got %h expected %h", got, exp); end
    @(posedge clk); #1;
    sb.push_back({1'b0, 64'h0F, 1'b0, 1'b0});
    send(0, 64'hFF, 64'h0F, 4'b0000);
    wait_resp();
    got = {resp_id, resp_result, resp_zero, resp_err}; exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL and_after_illegal: got %h expected %h", got, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    send(0, 64'd1, 64'd1, 4'b0010);
    rst = 1;
    @(posedge clk); #1;
    checks++;
    if ({resp_valid, resp_id, resp_result, resp_zero, resp_err, busy, req0_ready, req1_ready} !== 71'd0) begin
      failures++;
      $display("FAIL reset_mid: got v=%b id=%b r=%h z=%b e=%b busy=%b, expected all 0",
               resp_valid, resp_id, resp_result, resp_zero, resp_err, busy);
    end
    rst = 0;
    req0_a = 2; req0_b = 3; req0_op = 4'b0010; req0_valid = 1;
    req1_a = 6; req1_b = 3; req1_op = 4'b0111; req1_valid = 1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || resp_valid !== 1'b0) begin
      failures++; $display("FAIL tie_after_reset: got rdy=%b%b v=%b, expected rdy=10 v=0", req0_ready, req1_ready, resp_valid);
    end
    sb.push_back({1'b0, 64'd5, 1'b0, 1'b0});
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    wait_resp();
    got = {resp_id, resp_result, resp_zero, resp_err}; exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL post_reset_op: got %h expected %h", got, exp); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_zero_slt();
    test_round_robin();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
